// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_PC_WIDTH    = 16;
    localparam int unsigned FETCH_INSTR_WIDTH = 9;
    localparam int unsigned OFFSET_WIDTH      = 8;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_SEQ    = 2'd1,
        PC_BRANCH = 2'd2,
        PC_JUMP   = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC mux: hold, sequential increment, PC-relative branch, absolute jump.
module fetch_pc_next
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH = FETCH_PC_WIDTH
) (
    input  pc_sel_e                   sel,
    input  logic [PC_WIDTH-1:0]       pc,
    input  logic [PC_WIDTH-1:0]       ir_pc,
    input  logic [OFFSET_WIDTH-1:0]   branch_offset,
    input  logic [PC_WIDTH-1:0]       jump_target,
    output logic [PC_WIDTH-1:0]       pc_next_c
);

    logic [PC_WIDTH-1:0] offset_ext_c;

    // Size cast of a signed operand sign-extends the offset to PC width.
    assign offset_ext_c = PC_WIDTH'($signed(branch_offset));

    always_comb begin
        pc_next_c = pc;
        case (sel)
            PC_SEQ:    pc_next_c = pc + PC_WIDTH'(1);
            PC_BRANCH: pc_next_c = ir_pc + offset_ext_c;
            PC_JUMP:   pc_next_c = jump_target;
            default:   pc_next_c = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM addressing, IR latch, redirects, halt and end-of-program.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = FETCH_PC_WIDTH,
    parameter int unsigned INSTR_WIDTH = FETCH_INSTR_WIDTH,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned PROG_LEN    = 35
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      halt,
    input  logic                      branch_taken,
    input  logic [OFFSET_WIDTH-1:0]   branch_offset,
    input  logic                      jump_valid,
    input  logic [PC_WIDTH-1:0]       jump_target,
    input  logic [INSTR_WIDTH-1:0]    instr_in,
    output logic [PC_WIDTH-1:0]       pc_out,
    output logic [INSTR_WIDTH-1:0]    ir_out,
    output logic [PC_WIDTH-1:0]       ir_pc,
    output logic                      ir_valid,
    output logic                      halted
);

    localparam logic [0:0] S_RUN    = RUN;
    localparam logic [0:0] S_HALTED = HALTED;

    logic [0:0]             state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [PC_WIDTH-1:0]    ir_pc_q, ir_pc_d;
    logic                   ir_valid_q, ir_valid_d;
    pc_sel_e                pc_sel_c;
    logic [PC_WIDTH-1:0]    pc_next_c;
    logic                   end_of_prog_c;

    fetch_pc_next #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next (
        .sel           (pc_sel_c),
        .pc            (pc_q),
        .ir_pc         (ir_pc_q),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .pc_next_c     (pc_next_c)
    );

    assign end_of_prog_c = 32'(pc_q) >= PROG_LEN;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            pc_q       <= PC_WIDTH'(RESET_PC);
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // Next state in priority order: halt > stall > jump > branch > end-of-program > sequential.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        pc_sel_c   = PC_HOLD;
        if (state_q == S_RUN) begin
            if (halt && ir_valid_q) begin
                state_d    = S_HALTED;
                ir_valid_d = 1'b0;
            end else if (stall) begin
                pc_sel_c = PC_HOLD;
            end else if (jump_valid && ir_valid_q) begin
                pc_sel_c   = PC_JUMP;
                pc_d       = pc_next_c;
                ir_valid_d = 1'b0;
            end else if (branch_taken && ir_valid_q) begin
                pc_sel_c   = PC_BRANCH;
                pc_d       = pc_next_c;
                ir_valid_d = 1'b0;
            end else if (end_of_prog_c) begin
                state_d    = S_HALTED;
                ir_valid_d = 1'b0;
            end else begin
                pc_sel_c   = PC_SEQ;
                pc_d       = pc_next_c;
                ir_d       = instr_in;
                ir_pc_d    = pc_q;
                ir_valid_d = 1'b1;
            end
        end
    end

    assign pc_out   = pc_q;
    assign ir_out   = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: default instance plus a wrap-around instance (RESET_PC=0xFFFF).
module tb_fetch_unit;

    typedef struct {
        int pc;
        int ir;
        int ir_pc;
        int valid;
        int halted;
    } m_t;

    typedef struct {
        m_t a;
        m_t b;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall, halt, br, jv;
    logic [7:0]  off;
    logic [15:0] tgt;
    logic [8:0]  instr_a, instr_b;
    logic [15:0] pc_a, irpc_a, pc_b, irpc_b;
    logic [8:0]  ir_a, ir_b;
    logic        val_a, val_b, hlt_a, hlt_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    m_t   ma, mb;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [8:0] rom(int a);
        return 9'((a * 37 + 11) ^ (a >> 3));
    endfunction

    assign instr_a = rom(int'(pc_a));
    assign instr_b = rom(int'(pc_b));

    fetch_unit dut_a (
        .clk (clk), .reset (reset), .stall (stall), .halt (halt),
        .branch_taken (br), .branch_offset (off), .jump_valid (jv), .jump_target (tgt),
        .instr_in (instr_a), .pc_out (pc_a), .ir_out (ir_a), .ir_pc (irpc_a),
        .ir_valid (val_a), .halted (hlt_a)
    );

    fetch_unit #(.RESET_PC (32'hFFFF), .PROG_LEN (32'h10000)) dut_b (
        .clk (clk), .reset (reset), .stall (stall), .halt (halt),
        .branch_taken (br), .branch_offset (off), .jump_valid (jv), .jump_target (tgt),
        .instr_in (instr_b), .pc_out (pc_b), .ir_out (ir_b), .ir_pc (irpc_b),
        .ir_valid (val_b), .halted (hlt_b)
    );

    // Reference behaviour of one clock edge, straight from the operating rules.
    function automatic m_t step(m_t s, int reset_pc, int prog_len);
        m_t n = s;
        int o;
        if (reset) begin
            n.pc = reset_pc; n.ir = 0; n.ir_pc = 0; n.valid = 0; n.halted = 0;
        end else if (s.halted != 0) begin
            n = s;
        end else if (halt && s.valid != 0) begin
            n.halted = 1; n.valid = 0;
        end else if (stall) begin
            n = s;
        end else if (jv && s.valid != 0) begin
            n.pc = int'(tgt); n.valid = 0;
        end else if (br && s.valid != 0) begin
            o = int'(off);
            if (o > 127) o = o - 256;
            n.pc = (s.ir_pc + o) & 32'hFFFF;
            n.valid = 0;
        end else if (s.pc >= prog_len) begin
            n.halted = 1; n.valid = 0;
        end else begin
            n.ir = int'(rom(s.pc)); n.ir_pc = s.pc; n.valid = 1;
            n.pc = (s.pc + 1) & 32'hFFFF;
        end
        return n;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each falling edge compares the state produced by the preceding rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("a_pc_out",   int'(pc_a),   e.a.pc);
            check("a_ir_valid", int'(val_a),  e.a.valid);
            check("a_halted",   int'(hlt_a),  e.a.halted);
            check("a_ir_pc",    int'(irpc_a), e.a.ir_pc);
            check("a_ir_out",   int'(ir_a),   e.a.ir);
            check("b_pc_out",   int'(pc_b),   e.b.pc);
            check("b_ir_valid", int'(val_b),  e.b.valid);
            check("b_halted",   int'(hlt_b),  e.b.halted);
            check("b_ir_pc",    int'(irpc_b), e.b.ir_pc);
            check("b_ir_out",   int'(ir_b),   e.b.ir);
        end
    end

    task automatic set_idle();
        reset = 1'b0; stall = 1'b0; halt = 1'b0; br = 1'b0; jv = 1'b0;
        off = 8'h00; tgt = 16'h0000;
    endtask

    // Apply current inputs for one edge and record the expected outcome.
    task automatic tick();
        exp_t e;
        ma = step(ma, 0, 35);
        mb = step(mb, 32'hFFFF, 32'h10000);
        e.a = ma;
        e.b = mb;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_a(int n);
        int k = 0;
        while (!(ma.valid != 0 && ma.ir_pc == n) && k < 100) begin
            tick();
            k++;
        end
        n_checks++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL wait_a_ir_pc_%0d: timed out, required ir_pc %0d", n, n);
        end
    endtask

    task automatic wait_b(int n);
        int k = 0;
        while (!(mb.valid != 0 && mb.ir_pc == n) && k < 100) begin
            tick();
            k++;
        end
        n_checks++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL wait_b_ir_pc_%0d: timed out, required ir_pc %0d", n, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        set_idle();
        reset = 1'b1;
        @(negedge clk);
        #1;
        tick();
        tick();
        reset = 1'b0;

        // Free run through the whole program into end-of-program halt.
        repeat (45) tick();

        // Backward branch from ir_pc=10 by -5.
        do_reset();
        wait_a(10);
        br = 1'b1; off = 8'hFB;
        tick();
        set_idle();
        repeat (8) tick();

        // Jump and branch together: jump wins.
        do_reset();
        wait_a(3);
        jv = 1'b1; tgt = 16'h0014; br = 1'b1; off = 8'h02;
        tick();
        set_idle();
        repeat (5) tick();

        // Three-cycle stall with a branch pulse in the middle.
        do_reset();
        wait_a(7);
        stall = 1'b1;
        tick();
        br = 1'b1; off = 8'hF0;
        tick();
        br = 1'b0;
        tick();
        set_idle();
        repeat (4) tick();

        // Halt, then redirects are ignored until reset.
        do_reset();
        wait_a(12);
        halt = 1'b1;
        tick();
        set_idle();
        repeat (10) begin
            br = 1'($urandom); jv = 1'($urandom);
            off = 8'($urandom); tgt = 16'($urandom_range(0, 30));
            tick();
        end
        do_reset();
        repeat (3) tick();

        // Wrap-around instance: branch at 0x0002 by -128.
        do_reset();
        wait_b(2);
        br = 1'b1; off = 8'h80;
        tick();
        set_idle();
        repeat (4) tick();

        // Randomised traffic with occasional resets.
        repeat (400) begin
            reset = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 3) == 0);
            halt  = ($urandom_range(0, 15) == 0);
            br    = ($urandom_range(0, 5) == 0);
            jv    = ($urandom_range(0, 7) == 0);
            off   = 8'($urandom);
            tgt   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
            tick();
        end

        set_idle();
        tick();
        @(negedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
